// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared widths, state encoding and grant decode for the memory arbiter
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_t;

  function automatic logic [1:0] state_to_grant(input arb_state_t st);
    logic [1:0] g;
    g = 2'b00;
    case (st)
      ST_GRANT0: g = 2'b01;
      ST_GRANT1: g = 2'b10;
      default:   g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-input round-robin select, rr_ptr names the preferred requester on a tie
module mem_arb_rr (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic [1:0] winner
);

  always_comb begin
    winner = 2'b00;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = rr_ptr ? 2'b10 : 2'b01;
      default: winner = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates I-cache (m0) and D-cache (m1) line requests onto one data memory
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [1:0]        grant_o,
  output logic              busy_o
);

  arb_state_t state;
  logic       rr_ptr;
  logic [1:0] winner;

  mem_arb_rr u_rr (
    .req    ({m1_enable_i, m0_enable_i}),
    .rr_ptr (rr_ptr),
    .winner (winner)
  );

  // Acks are only forwarded to the current owner, so a stray memory ack in IDLE is dropped.
  assign m0_ack_o  = (state == ST_GRANT0) && mem_ack_i;
  assign m1_ack_o  = (state == ST_GRANT1) && mem_ack_i;
  assign m0_data_o = m0_ack_o ? mem_data_i : '0;
  assign m1_data_o = m1_ack_o ? mem_data_i : '0;
  assign grant_o   = state_to_grant(state);
  assign busy_o    = |grant_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      rr_ptr       <= 1'b0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (winner[0]) begin
            state        <= ST_GRANT0;
            mem_enable_o <= 1'b1;
            mem_write_o  <= m0_write_i;
            mem_addr_o   <= m0_addr_i;
            mem_data_o   <= m0_data_i;
          end else if (winner[1]) begin
            state        <= ST_GRANT1;
            mem_enable_o <= 1'b1;
            mem_write_o  <= m1_write_i;
            mem_addr_o   <= m1_addr_i;
            mem_data_o   <= m1_data_i;
          end
        end
        ST_GRANT0: begin
          if (mem_ack_i) begin
            state        <= ST_IDLE;
            rr_ptr       <= 1'b1;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
          end else begin
            // Enable stays up even if the requester drops early, so the memory still completes.
            mem_write_o <= m0_write_i;
            mem_addr_o  <= m0_addr_i;
            mem_data_o  <= m0_data_i;
          end
        end
        ST_GRANT1: begin
          if (mem_ack_i) begin
            state        <= ST_IDLE;
            rr_ptr       <= 1'b0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
          end else begin
            mem_write_o <= m1_write_i;
            mem_addr_o  <= m1_addr_i;
            mem_data_o  <= m1_data_i;
          end
        end
        default: begin
          state        <= ST_IDLE;
          mem_enable_o <= 1'b0;
          mem_write_o  <= 1'b0;
          mem_addr_o   <= '0;
          mem_data_o   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a 10-cycle-latency memory model
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;

  logic          clk_i;
  logic          rst_i;
  logic          m0_enable_i, m0_write_i;
  logic [AW-1:0] m0_addr_i;
  logic [DW-1:0] m0_data_i;
  logic          m0_ack_o;
  logic [DW-1:0] m0_data_o;
  logic          m1_enable_i, m1_write_i;
  logic [AW-1:0] m1_addr_i;
  logic [DW-1:0] m1_data_i;
  logic          m1_ack_o;
  logic [DW-1:0] m1_data_o;
  logic          mem_enable_o, mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_data_i;
  logic [1:0]    grant_o;
  logic          busy_o;

  logic model_ack;
  logic spurious_ack;
  int   model_cnt;

  assign mem_ack_i = model_ack | spurious_ack;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .m0_enable_i  (m0_enable_i),
    .m0_write_i   (m0_write_i),
    .m0_addr_i    (m0_addr_i),
    .m0_data_i    (m0_data_i),
    .m0_ack_o     (m0_ack_o),
    .m0_data_o    (m0_data_o),
    .m1_enable_i  (m1_enable_i),
    .m1_write_i   (m1_write_i),
    .m1_addr_i    (m1_addr_i),
    .m1_data_i    (m1_data_i),
    .m1_ack_o     (m1_ack_o),
    .m1_data_o    (m1_data_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i),
    .grant_o      (grant_o),
    .busy_o       (busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    int            who;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] grant_hist[$];
  int         tests_run;
  int         tests_failed;

  function automatic logic [DW-1:0] read_line(input logic [AW-1:0] a);
    if (a == 32'h0000_0040) return {16{16'hECFA}};
    return {8{a ^ 32'hA5A5_0000}};
  endfunction

  // Memory model: acks 10 cycles after enable rises, returns read_line for reads and 0 for writes.
  always @(posedge clk_i) begin
    #1;
    if (rst_i) begin
      model_ack  = 1'b0;
      model_cnt  = 0;
      mem_data_i = '0;
    end else if (model_ack) begin
      model_ack  = 1'b0;
      model_cnt  = 0;
      mem_data_i = '0;
    end else if (mem_enable_o) begin
      model_cnt = model_cnt + 1;
      if (model_cnt == 10) begin
        model_ack  = 1'b1;
        mem_data_i = mem_write_o ? '0 : read_line(mem_addr_o);
      end
    end else begin
      model_cnt = 0;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int who, input logic wr, input logic [AW-1:0] addr);
    exp_t e;
    e.who  = who;
    e.wr   = wr;
    e.addr = addr;
    e.data = wr ? '0 : read_line(addr);
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t       e;
    logic [1:0] last;
    last = 2'b00;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (m0_ack_o || m1_ack_o) begin
          if (sb.size() == 0) begin
            check("unexp_ack", 256'd1, 256'd0);
          end else begin
            e = sb.pop_front();
            check("sb_who", m1_ack_o ? 256'd1 : 256'd0, 256'(e.who));
            check("sb_addr", 256'(mem_addr_o), 256'(e.addr));
            check("sb_wr", 256'(mem_write_o), 256'(e.wr));
            check("sb_data", m1_ack_o ? m1_data_o : m0_data_o, e.data);
          end
        end
        check("ack_excl", 256'(m0_ack_o & m1_ack_o), 256'd0);
        if (!m0_ack_o) check("m0_data_zero", m0_data_o, '0);
        if (!m1_ack_o) check("m1_data_zero", m1_data_o, '0);
        check("busy", 256'(busy_o), 256'(|grant_o));
      end
      if (grant_o != last) begin
        grant_hist.push_back(grant_o);
        last = grant_o;
      end
    end
  endtask

  task automatic set_req(input int who, input logic en, input logic wr,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (who == 0) begin
      m0_enable_i = en; m0_write_i = wr; m0_addr_i = addr; m0_data_i = data;
    end else begin
      m1_enable_i = en; m1_write_i = wr; m1_addr_i = addr; m1_data_i = data;
    end
  endtask

  task automatic wait_ack(input int who);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk_i);
      seen = (who == 0) ? m0_ack_o : m1_ack_o;
    end
    check("ack_seen", 256'(seen), 256'd1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic txn(input int who, input int n, input logic wr,
                     input logic [AW-1:0] base, input logic [DW-1:0] data);
    for (int i = 0; i < n; i++) begin
      set_req(who, 1'b1, wr, base + AW'(i) * 32'h40, data);
      wait_ack(who);
    end
    set_req(who, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_hist_01_00_10_00(input string tag);
    logic [1:0] exp_seq[4];
    exp_seq = '{2'b01, 2'b00, 2'b10, 2'b00};
    check({tag, "_len"}, 256'(grant_hist.size()), 256'd4);
    for (int i = 0; i < 4 && i < grant_hist.size(); i++)
      check({tag, "_seq"}, 256'(grant_hist[i]), 256'(exp_seq[i]));
  endtask

  logic [DW-1:0] wdata;

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst_i = 1'b1;
    spurious_ack = 1'b0;
    model_ack = 1'b0;
    model_cnt = 0;
    mem_data_i = '0;
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
    wdata = {2{128'h0123456789ABCDEFFEDCBA9876543210}};
    fork monitor(); join_none

    repeat (3) @(negedge clk_i);
    check("rst_grant", 256'(grant_o), 256'd0);
    check("rst_busy", 256'(busy_o), 256'd0);
    check("rst_mem_en", 256'(mem_enable_o), 256'd0);
    check("rst_acks", 256'({m1_ack_o, m0_ack_o}), 256'd0);

    // Both request in the first cycle after reset: m0 preferred, one idle cycle, then m1.
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    grant_hist.delete();
    push_exp(0, 1'b0, 32'h100);
    push_exp(1, 1'b0, 32'h140);
    fork
      txn(0, 1, 1'b0, 32'h100, '0);
      txn(1, 1, 1'b0, 32'h140, '0);
    join
    repeat (2) @(negedge clk_i);
    check_hist_01_00_10_00("simul");

    // m1 read of 0x40 alone, checking one-cycle arbitration latency.
    @(posedge clk_i); #1;
    push_exp(1, 1'b0, 32'h40);
    fork
      txn(1, 1, 1'b0, 32'h40, '0);
      begin
        @(negedge clk_i);
        check("lat_arb_cycle", 256'(mem_enable_o), 256'd0);
        @(negedge clk_i);
        check("lat_mem_en", 256'(mem_enable_o), 256'd1);
        check("lat_grant", 256'(grant_o), 256'd2);
      end
    join

    // Both held for two transactions each: strict alternation m0, m1, m0, m1.
    @(posedge clk_i); #1;
    push_exp(0, 1'b0, 32'h1000);
    push_exp(1, 1'b0, 32'h2000);
    push_exp(0, 1'b0, 32'h1040);
    push_exp(1, 1'b0, 32'h2040);
    fork
      txn(0, 2, 1'b0, 32'h1000, '0);
      txn(1, 2, 1'b0, 32'h2000, '0);
    join

    // m1 line write: direction and data forwarded throughout the grant.
    @(posedge clk_i); #1;
    push_exp(1, 1'b1, 32'h200);
    fork
      txn(1, 1, 1'b1, 32'h200, wdata);
      begin
        @(negedge clk_i);
        for (int c = 0; c < 20; c++) begin
          @(negedge clk_i);
          check("wr_dir", 256'(mem_write_o), 256'd1);
          check("wr_data", mem_data_o, wdata);
          if (m1_ack_o) break;
        end
      end
    join

    // Spurious memory ack while idle.
    @(posedge clk_i); #1;
    spurious_ack = 1'b1;
    @(negedge clk_i);
    check("spur_acks", 256'({m1_ack_o, m0_ack_o}), 256'd0);
    @(posedge clk_i); #1;
    spurious_ack = 1'b0;
    @(negedge clk_i);
    check("spur_idle", 256'(grant_o), 256'd0);
    check("spur_mem_en", 256'(mem_enable_o), 256'd0);

    // Serve m0 so the pointer favours m1, then reset mid-way through an m1 read.
    @(posedge clk_i); #1;
    push_exp(0, 1'b0, 32'h180);
    txn(0, 1, 1'b0, 32'h180, '0);
    set_req(1, 1'b1, 1'b0, 32'h300, '0);
    repeat (6) @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    set_req(1, 1'b0, 1'b0, '0, '0);
    #1;
    check("arst_mem_en", 256'(mem_enable_o), 256'd0);
    check("arst_grant", 256'(grant_o), 256'd0);
    check("arst_busy", 256'(busy_o), 256'd0);
    check("arst_ack", 256'(m1_ack_o), 256'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (15) @(negedge clk_i);
    check("post_rst_idle", 256'(grant_o), 256'd0);
    @(posedge clk_i); #1;
    grant_hist.delete();
    push_exp(0, 1'b0, 32'h400);
    push_exp(1, 1'b0, 32'h440);
    fork
      txn(0, 1, 1'b0, 32'h400, '0);
      txn(1, 1, 1'b0, 32'h440, '0);
    join
    repeat (2) @(negedge clk_i);
    check_hist_01_00_10_00("post_rst");

    repeat (3) @(negedge clk_i);
    check("sb_empty", 256'(sb.size()), 256'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, is the address width of every address port.
REQ-002 Parameter DATA_W, default 256, is the cache-line width of every data port.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 m0_enable_i / m1_enable_i  input  1  request from requester 0 (I-cache) / requester 1 (D-cache); held until that requester's ack.
REQ-006 m0_write_i / m1_write_i  input  1  1 = line write, 0 = line read.
REQ-007 m0_addr_i / m1_addr_i  input  ADDR_W  line address; stable while enable is high.
REQ-008 m0_data_i / m1_data_i  input  DATA_W  write line; stable while enable is high.
REQ-009 m0_ack_o / m1_ack_o  output  1  one-cycle completion pulse to the granted requester.
REQ-010 m0_data_o / m1_data_o  output  DATA_W  read line; valid only while the matching ack is high.
REQ-011 mem_enable_o, mem_write_o  output  1  request and direction to the shared data memory.
REQ-012 mem_addr_o  output  ADDR_W  and  mem_data_o  output  DATA_W: forwarded address and write line.
REQ-013 mem_ack_i  input  1  and  mem_data_i  input  DATA_W: memory completion pulse and read line.
REQ-014 grant_o  output  2  one-hot current owner (bit0 = m0, bit1 = m1); busy_o  output  1  = grant_o != 0.

Function
REQ-015 FSM states: IDLE, GRANT0, GRANT1; state register only, no other storage beyond the RR pointer and output registers.
REQ-016 IDLE: no request -> stay; only mN requests -> GRANTN; both request -> grant the requester named by rr_ptr.
REQ-017 mem_enable_o, mem_write_o, mem_addr_o, mem_data_o are registered: asserted/loaded from the first cycle after the IDLE arbitration cycle (1-cycle arbitration latency).
REQ-018 In GRANTN the forwarded outputs reflect mN inputs every cycle; the other requester's inputs are ignored.
REQ-019 In GRANTN with mem_ack_i = 1: mN_ack_o = 1 and mN_data_o = mem_data_i combinationally in that same cycle; next state IDLE.
REQ-020 The non-granted ack output is 0 at all times; mN_data_o is 0 when mN_ack_o = 0.
REQ-021 mem_enable_o is 0 in the cycle after ack (IDLE), giving at least one idle cycle between memory transactions.
REQ-022 rr_ptr toggles to the other requester on each completed grant (ack cycle); it does not change while waiting.
REQ-023 Back-to-back requests from both masters alternate strictly: neither requester waits more than one foreign transaction.
REQ-024 mem_ack_i in IDLE is ignored (no ack forwarded, no state change).
REQ-025 Requester dropping enable before ack: grant is held until mem_ack_i; the ack is still pulsed to that requester.
REQ-026 Requester contract: after its ack it deasserts enable the next cycle unless it issues a new transaction.

Reset
REQ-027 rst_i high forces, asynchronously: state IDLE, rr_ptr = 0 (m0 preferred), all outputs 0.
REQ-028 Reset mid-transaction abandons it; no ack is issued for it after reset release.
REQ-029 First arbitration is in the first rising edge with rst_i low.

Structure
REQ-030 Shared package mem_arb_pkg holds ADDR_W/DATA_W defaults and the 2-bit state encoding (IDLE=0, GRANT0=1, GRANT1=2).
REQ-031 Optional sub-module mem_arb_rr: 2-input round-robin select (requests, rr_ptr -> one-hot winner); all else in mem_arbiter.

Verification (bench memory model acks 10 cycles after enable rises)
REQ-032 m1 read 0x00000040 alone -> mem_enable_o high 1 cycle later, m1_ack_o pulses once with m1_data_o = line ECFA..ECFA; m0_ack_o stays 0.
REQ-033 m0 and m1 request same cycle after reset -> m0 served first, then one idle cycle, then m1; grant_o 01 -> 00 -> 10.
REQ-034 Both hold requests continuously for 4 transactions -> grant order m0, m1, m0, m1.
REQ-035 m1 write 0x00000200 data 0x0123..3210 -> mem_write_o = 1, mem_data_o equals input throughout grant; ack pulses once.
REQ-036 rst_i pulsed 5 cycles into a GRANT1 read -> outputs 0 immediately, no m1_ack_o afterward, next simultaneous request grants m0.
REQ-037 Spurious mem_ack_i in IDLE -> no ack outputs, state stays IDLE.
